// File: rtl/pico_sequencer.sv
// Purpose: multi-cycle fetch/decode/exec/writeback control FSM for the picoMIPS core.
// Latency: 4 cycles per instruction, 3+mul_latency for MUL, WAIT adds one cycle per io_ready-low cycle.
// Backpressure: run gates instruction fetch; io_ready stalls WAIT; HALT holds until reset.
`ifndef PROGRAM_CODE_SIZE
`define PROGRAM_CODE_SIZE 8
`endif

module pico_sequencer #(
   parameter int program_code_size = `PROGRAM_CODE_SIZE,
   parameter int mul_latency       = 3,
   parameter int state_width       = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic [2:0]             opcode,
   input  logic                   zero,
   input  logic                   io_ready,
   output logic                   pc_inc,
   output logic                   pc_load,
   output logic                   ir_load,
   output logic                   alu_en,
   output logic                   reg_we,
   output logic                   io_ack,
   output logic                   halted,
   output logic [state_width-1:0] state
);

   // Reject parameter values the counter and address width cannot represent.
   if (mul_latency < 1 || mul_latency > 15 || program_code_size < 1) begin : g_bad_param
      $error("pico_sequencer: illegal parameter value");
   end

   localparam logic [2:0] st_fetch   = 3'd0;
   localparam logic [2:0] st_decode  = 3'd1;
   localparam logic [2:0] st_exec    = 3'd2;
   localparam logic [2:0] st_wait_io = 3'd3;
   localparam logic [2:0] st_wb      = 3'd4;
   localparam logic [2:0] st_halt    = 3'd5;

   localparam logic [2:0] op_nop  = 3'b000;
   localparam logic [2:0] op_add  = 3'b001;
   localparam logic [2:0] op_addi = 3'b010;
   localparam logic [2:0] op_mul  = 3'b011;
   localparam logic [2:0] op_beq  = 3'b100;
   localparam logic [2:0] op_jmp  = 3'b101;
   localparam logic [2:0] op_wait = 3'b110;
   localparam logic [2:0] op_halt = 3'b111;

   // Last EXEC cycle of a MUL: cnt counts 0..mul_latency-1.
   localparam logic [3:0] cnt_last = 4'(mul_latency - 1);

   logic [2:0] st_q;
   logic [2:0] st_d;
   logic [2:0] op_reg;
   logic       flag_reg;
   logic [3:0] cnt;
   logic       writes_reg;
   logic       takes_branch;

   assign writes_reg   = (op_reg == op_add) || (op_reg == op_addi) || (op_reg == op_mul);
   assign takes_branch = (op_reg == op_jmp) || ((op_reg == op_beq) && flag_reg);

   // Next-state selection; illegal codes fall back to FETCH.
   always_comb begin
      st_d = st_fetch;
      case (st_q)
         st_fetch:   st_d = run ? st_decode : st_fetch;
         st_decode: begin
            if (opcode == op_halt)      st_d = st_halt;
            else if (opcode == op_wait) st_d = st_wait_io;
            else                        st_d = st_exec;
         end
         st_exec:    st_d = ((op_reg == op_mul) && (cnt != cnt_last)) ? st_exec : st_wb;
         st_wait_io: st_d = io_ready ? st_wb : st_wait_io;
         st_wb:      st_d = st_fetch;
         st_halt:    st_d = st_halt;
         default:    st_d = st_fetch;
      endcase
   end

   // State, latched opcode, branch flag and MUL cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q     <= st_fetch;
         op_reg   <= 3'b000;
         flag_reg <= 1'b0;
         cnt      <= 4'd0;
      end else begin
         st_q <= st_d;
         if (st_q == st_decode) begin
            op_reg <= opcode;
            cnt    <= 4'd0;
         end
         if (st_q == st_exec) begin
            flag_reg <= zero;
            if (op_reg == op_mul) cnt <= cnt + 4'd1;
         end
      end
   end

   // Unregistered strobe decode; everything is forced low while reset is high.
   always_comb begin
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      ir_load = 1'b0;
      alu_en  = 1'b0;
      reg_we  = 1'b0;
      io_ack  = 1'b0;
      halted  = 1'b0;
      if (!reset) begin
         case (st_q)
            st_fetch: ir_load = run;
            st_exec:  alu_en  = (op_reg == op_add) || (op_reg == op_addi) ||
                                (op_reg == op_mul) || (op_reg == op_beq);
            st_wait_io: begin
               io_ack = io_ready;
               reg_we = io_ready;
            end
            st_wb: begin
               reg_we  = writes_reg;
               pc_load = takes_branch;
               pc_inc  = !takes_branch;
            end
            st_halt:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign state = state_width'(st_q);

endmodule

// File: tb/tb_pico_sequencer.sv
// Purpose: directed self-checking bench for pico_sequencer (table vectors plus corner sequences).
// Latency: one vector per clock; inputs driven at negedge, outputs compared 1 ns later.
// Backpressure: none; every wait is a fixed number of cycles.
`timescale 1ns/1ps

module tb_pico_sequencer;

   logic       clk = 1'b0;
   logic       reset, run, zero, io_ready;
   logic [2:0] opcode;
   logic       pc_inc, pc_load, ir_load, alu_en, reg_we, io_ack, halted;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   int pc_inc_seen = 0;
   int reg_we_seen = 0;
   int io_ack_seen = 0;

   // Expected-output bit positions: {pc_inc, pc_load, ir_load, alu_en, reg_we, io_ack, halted}
   localparam logic [6:0] PI = 7'b1000000;
   localparam logic [6:0] PL = 7'b0100000;
   localparam logic [6:0] IR = 7'b0010000;
   localparam logic [6:0] AE = 7'b0001000;
   localparam logic [6:0] WE = 7'b0000100;
   localparam logic [6:0] AK = 7'b0000010;
   localparam logic [6:0] HL = 7'b0000001;
   localparam logic [6:0] NO = 7'b0000000;

   typedef struct {
      logic       rst;
      logic       run;
      logic [2:0] op;
      logic       z;
      logic       io;
      logic [6:0] exp_out;
      logic [2:0] exp_st;
   } vec_t;

   vec_t vecs[$];

   pico_sequencer #(.program_code_size(8), .mul_latency(3), .state_width(3)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
      .io_ready(io_ready), .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
      .alu_en(alu_en), .reg_we(reg_we), .io_ack(io_ack), .halted(halted), .state(state)
   );

   always #5 clk = ~clk;

   task automatic add_vec(input logic r, input logic rn, input logic [2:0] op, input logic z,
                          input logic io, input logic [6:0] eo, input logic [2:0] es);
      vec_t v;
      v.rst = r; v.run = rn; v.op = op; v.z = z; v.io = io; v.exp_out = eo; v.exp_st = es;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs at negedge, then compare outputs and state before the next posedge.
   task automatic apply(input logic r, input logic rn, input logic [2:0] op, input logic z,
                        input logic io, input logic [6:0] eo, input logic [2:0] es,
                        input string name);
      logic [6:0] got;
      @(negedge clk);
      reset = r; run = rn; opcode = op; zero = z; io_ready = io;
      #1;
      got = {pc_inc, pc_load, ir_load, alu_en, reg_we, io_ack, halted};
      checks++;
      if (got !== eo || state !== es) begin
         errors++;
         $display("FAIL %s: got out=%b state=%0d, expected out=%b state=%0d", name, got, state, eo, es);
      end
      if (pc_inc === 1'b1) pc_inc_seen++;
      if (reg_we === 1'b1) reg_we_seen++;
      if (io_ack === 1'b1) io_ack_seen++;
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      int pi0, we0;
      reset = 1'b1; run = 1'b0; opcode = 3'b000; zero = 1'b0; io_ready = 1'b0;
      @(negedge clk);

      // Reset state, then three ADDs back to back with run held high.
      add_vec(1, 1, 3'b001, 0, 0, NO, 3'd0);
      for (int i = 0; i < 3; i++) begin
         add_vec(0, 1, 3'b001, 0, 0, IR, 3'd0);
         add_vec(0, 1, 3'b001, 0, 0, NO, 3'd1);
         add_vec(0, 1, 3'b001, 0, 0, AE, 3'd2);
         add_vec(0, 1, 3'b001, 0, 0, PI | WE, 3'd4);
      end
      foreach (vecs[i])
         apply(vecs[i].rst, vecs[i].run, vecs[i].op, vecs[i].z, vecs[i].io,
               vecs[i].exp_out, vecs[i].exp_st, $sformatf("add_vec%0d", i));
      check_int("pc_inc_after_3_add", pc_inc_seen, 3);
      vecs.delete();

      // MUL: three EXEC cycles with alu_en, WB on cycle 6.
      add_vec(0, 1, 3'b011, 0, 0, IR, 3'd0);
      add_vec(0, 1, 3'b011, 0, 0, NO, 3'd1);
      add_vec(0, 1, 3'b011, 0, 0, AE, 3'd2);
      add_vec(0, 1, 3'b011, 0, 0, AE, 3'd2);
      add_vec(0, 1, 3'b011, 0, 0, AE, 3'd2);
      add_vec(0, 1, 3'b011, 0, 0, PI | WE, 3'd4);
      // BEQ taken: zero=1 in EXEC; zero dropping in WB must not matter.
      add_vec(0, 1, 3'b100, 0, 0, IR, 3'd0);
      add_vec(0, 1, 3'b100, 0, 0, NO, 3'd1);
      add_vec(0, 1, 3'b100, 1, 0, AE, 3'd2);
      add_vec(0, 1, 3'b100, 0, 0, PL, 3'd4);
      // BEQ not taken: zero=0 in EXEC; zero rising in WB must not matter.
      add_vec(0, 1, 3'b100, 1, 0, IR, 3'd0);
      add_vec(0, 1, 3'b100, 1, 0, NO, 3'd1);
      add_vec(0, 1, 3'b100, 0, 0, AE, 3'd2);
      add_vec(0, 1, 3'b100, 1, 0, PI, 3'd4);
      // JMP: no alu_en, pc_load, no reg_we.
      add_vec(0, 1, 3'b101, 0, 0, IR, 3'd0);
      add_vec(0, 1, 3'b101, 0, 0, NO, 3'd1);
      add_vec(0, 1, 3'b101, 0, 0, NO, 3'd2);
      add_vec(0, 1, 3'b101, 0, 0, PL, 3'd4);
      // NOP with opcode changing to HALT after DECODE: ignored.
      add_vec(0, 1, 3'b000, 0, 0, IR, 3'd0);
      add_vec(0, 1, 3'b000, 0, 0, NO, 3'd1);
      add_vec(0, 1, 3'b111, 0, 0, NO, 3'd2);
      add_vec(0, 1, 3'b111, 0, 0, PI, 3'd4);
      // ADDI with run dropped after FETCH: completes, then idles.
      add_vec(0, 1, 3'b010, 0, 0, IR, 3'd0);
      add_vec(0, 0, 3'b010, 0, 0, NO, 3'd1);
      add_vec(0, 0, 3'b010, 0, 0, AE, 3'd2);
      add_vec(0, 0, 3'b010, 0, 0, PI | WE, 3'd4);
      add_vec(0, 0, 3'b010, 0, 0, NO, 3'd0);
      add_vec(0, 0, 3'b010, 0, 0, NO, 3'd0);
      foreach (vecs[i])
         apply(vecs[i].rst, vecs[i].run, vecs[i].op, vecs[i].z, vecs[i].io,
               vecs[i].exp_out, vecs[i].exp_st, $sformatf("instr_vec%0d", i));

      // WAIT with io_ready low for 5 cycles, then high.
      io_ack_seen = 0;
      we0 = reg_we_seen;
      apply(0, 1, 3'b110, 0, 0, IR, 3'd0, "wait_fetch");
      apply(0, 0, 3'b110, 0, 0, NO, 3'd1, "wait_decode");
      for (int i = 0; i < 5; i++)
         apply(0, 0, 3'b000, 0, 0, NO, 3'd3, $sformatf("wait_io_low%0d", i));
      apply(0, 0, 3'b000, 0, 1, AK | WE, 3'd3, "wait_io_high");
      apply(0, 0, 3'b000, 0, 1, PI, 3'd4, "wait_wb");
      apply(0, 0, 3'b000, 0, 1, NO, 3'd0, "wait_back_fetch");
      check_int("wait_io_ack_count", io_ack_seen, 1);
      check_int("wait_reg_we_count", reg_we_seen - we0, 1);

      // HALT: sticky for 20 cycles whatever run and io_ready do.
      apply(0, 1, 3'b111, 0, 0, IR, 3'd0, "halt_fetch");
      apply(0, 1, 3'b111, 0, 0, NO, 3'd1, "halt_decode");
      pi0 = pc_inc_seen;
      for (int i = 0; i < 20; i++)
         apply(0, 1'(i), 3'b001, 1'(i >> 1), 1'(i >> 2), HL, 3'd5, $sformatf("halt_hold%0d", i));
      check_int("halt_no_pc_inc", pc_inc_seen - pi0, 0);
      apply(1, 1, 3'b011, 0, 1, NO, 3'd5, "halt_reset_cycle");
      apply(0, 1, 3'b011, 0, 0, IR, 3'd0, "halt_resume_fetch");

      // Reset during the second MUL EXEC cycle aborts the instruction.
      pi0 = pc_inc_seen;
      we0 = reg_we_seen;
      apply(0, 0, 3'b011, 0, 0, NO, 3'd1, "abort_decode");
      apply(0, 0, 3'b011, 0, 0, AE, 3'd2, "abort_exec0");
      apply(1, 0, 3'b011, 0, 0, NO, 3'd2, "abort_exec1_reset");
      for (int i = 0; i < 10; i++)
         apply(0, 0, 3'b011, 1, 1, NO, 3'd0, $sformatf("idle_run0_%0d", i));
      check_int("abort_no_pc_inc", pc_inc_seen - pi0, 0);
      check_int("abort_no_reg_we", reg_we_seen - we0, 0);

      // Fetch resumes cleanly after the abort.
      apply(0, 1, 3'b001, 0, 0, IR, 3'd0, "post_abort_fetch");
      apply(0, 1, 3'b001, 0, 0, NO, 3'd1, "post_abort_decode");
      apply(0, 1, 3'b001, 0, 0, AE, 3'd2, "post_abort_exec");
      apply(0, 0, 3'b001, 0, 0, PI | WE, 3'd4, "post_abort_wb");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
